// File: rtl/gate_check_pkg.sv
// Shared definitions for the basic_gates truth-table checker: gate_out bit
// positions, checker FSM states and the golden gate function.
package gate_check_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int GATE_BITS   = 7;

  localparam int BIT_AND   = 0;
  localparam int BIT_NAND  = 1;
  localparam int BIT_OR    = 2;
  localparam int BIT_NOR   = 3;
  localparam int BIT_NOT_A = 4;
  localparam int BIT_XOR   = 5;
  localparam int BIT_XNOR  = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [GATE_BITS-1:0] expected(input logic a, input logic b);
    logic [GATE_BITS-1:0] e;
    e            = '0;
    e[BIT_AND]   = a & b;
    e[BIT_NAND]  = ~(a & b);
    e[BIT_OR]    = a | b;
    e[BIT_NOR]   = ~(a | b);
    e[BIT_NOT_A] = ~a;
    e[BIT_XOR]   = a ^ b;
    e[BIT_XNOR]  = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Link between the checker and basic_gates: the checker drives a/b and
// consumes the seven gate results.
interface gate_truth_checker_if;
  import gate_check_pkg::*;

  logic                 a;
  logic                 b;
  logic [GATE_BITS-1:0] gate_out;

  modport master (output a, output b, input gate_out);
  modport slave  (input a, input b, output gate_out);
endinterface

// File: rtl/gate_truth_checker_golden.sv
// Combinational golden model of basic_gates; reusable by other benches.
module gate_golden
  import gate_check_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [GATE_BITS-1:0] expected_out
);

  assign expected_out = expected(a, b);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps (a,b) through 00,01,10,11 into basic_gates, holding each vector
// HOLD_CYCLES cycles, and compares the gate results against the golden model.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  gate_truth_checker_if.master        gate_bus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [2:0]                  err_count,
  output logic [GATE_BITS-1:0]        fail_mask
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    VEC_LAST  = 2'(NUM_VECTORS - 1);

  state_t               state;
  logic [CW-1:0]        hold_cnt;
  logic [1:0]           vec_idx;
  logic                 a_q;
  logic                 b_q;
  logic [GATE_BITS-1:0] golden;
  logic [GATE_BITS-1:0] mismatch;
  logic [2:0]           err_next;
  logic [1:0]           vec_next;

  gate_golden u_golden (
    .a            (a_q),
    .b            (b_q),
    .expected_out (golden)
  );

  assign gate_bus.a = a_q;
  assign gate_bus.b = b_q;
  assign mismatch   = golden ^ gate_bus.gate_out;
  assign err_next   = err_count + {2'b00, |mismatch};
  assign vec_next   = vec_idx + 2'd1;

  // pass must reflect the compare of the last vector, so it uses err_next
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_idx   <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            hold_cnt  <= '0;
            vec_idx   <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
          end
        end
        RUN: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt  <= '0;
            fail_mask <= fail_mask | mismatch;
            err_count <= err_next;
            if (vec_idx == VEC_LAST) begin
              state   <= DONE;
              done    <= 1'b1;
              pass    <= (err_next == 3'd0);
              vec_idx <= '0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
            end else begin
              vec_idx <= vec_next;
              a_q     <= vec_next[1];
              b_q     <= vec_next[0];
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker with a fault-injectable basic_gates
// stand-in; expected sweep results are hand-computed per fault mode.
module tb_gate_truth_checker;

  logic clk;
  logic rst_n;
  logic start4;
  logic start1;
  logic [1:0] fault_mode;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic       busy4, done4, pass4, busy1, done1, pass1;
  logic [2:0] err4, err1;
  logic [6:0] mask4, mask1;

  typedef struct {
    int         start_cyc;
    int         latency;
    logic [2:0] err;
    logic [6:0] mask;
    logic       pass;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  gate_truth_checker_if bus4 ();
  gate_truth_checker_if bus1 ();

  gate_truth_checker #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .gate_bus(bus4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_mask(mask4)
  );

  gate_truth_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  // basic_gates stand-in: mode 0 correct, 1 XOR stuck at 0, 2 all outputs stuck at 1
  function automatic logic [6:0] gates(input logic a, input logic b, input logic [1:0] mode);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
    if (mode == 2'd1) g[5] = 1'b0;
    if (mode == 2'd2) g = 7'h7F;
    return g;
  endfunction

  assign bus4.gate_out = gates(bus4.a, bus4.b, fault_mode);
  assign bus1.gate_out = gates(bus1.a, bus1.b, fault_mode);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    checks++;
    if (actual !== expect_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expect_v, cyc);
    end
  endtask

  task automatic applyStimulus(input bit use1, input logic [1:0] mode, input bit expect_done,
                               input logic [2:0] e_err, input logic [6:0] e_mask, input logic e_pass);
    exp_t e;
    @(negedge clk);
    fault_mode  = mode;
    e.start_cyc = cyc;
    e.latency   = use1 ? 5 : 17;
    e.err       = e_err;
    e.mask      = e_mask;
    e.pass      = e_pass;
    if (use1) begin
      if (expect_done) q1.push_back(e);
      start1 = 1'b1;
    end else begin
      if (expect_done) q4.push_back(e);
      start4 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic waitDrained(input string name);
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain_timeout"}, q4.size() + q1.size(), 0);
  endtask

  // Monitors: every done pulse must match the oldest outstanding sweep
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        checkOutput("unexpected_done4", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        checkOutput("lat4",  cyc - e.start_cyc, e.latency);
        checkOutput("err4",  err4,  e.err);
        checkOutput("mask4", mask4, e.mask);
        checkOutput("pass4", pass4, e.pass);
        checkOutput("busy_at_done4", busy4, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_done1", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        checkOutput("lat1",  cyc - e.start_cyc, e.latency);
        checkOutput("err1",  err1,  e.err);
        checkOutput("mask1", mask1, e.mask);
        checkOutput("pass1", pass1, e.pass);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n      = 1'b0;
    start4     = 1'b0;
    start1     = 1'b0;
    fault_mode = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_a",    bus4.a, 0);
    checkOutput("rst_b",    bus4.b, 0);
    checkOutput("rst_busy", busy4,  0);
    checkOutput("rst_done", done4,  0);
    checkOutput("rst_pass", pass4,  0);
    checkOutput("rst_err",  err4,   0);
    checkOutput("rst_mask", mask4,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // correct gates, HOLD_CYCLES=4
    applyStimulus(1'b0, 2'd0, 1'b1, 3'd0, 7'h00, 1'b1);
    waitDrained("good4");

    // XOR stuck at 0: vectors 01 and 10 fail
    applyStimulus(1'b0, 2'd1, 1'b1, 3'd2, 7'b0100000, 1'b0);
    waitDrained("xor4");

    // HOLD_CYCLES=1: vectors advance every cycle
    applyStimulus(1'b1, 2'd0, 1'b1, 3'd0, 7'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("ab_seq1", {bus1.a, bus1.b}, k);
      if (k < 3) @(negedge clk);
    end
    waitDrained("good1");

    // start pulsed mid-run must be ignored
    applyStimulus(1'b0, 2'd0, 1'b1, 3'd0, 7'h00, 1'b1);
    repeat (6) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waitDrained("ignore_start");
    checkOutput("pass_held", pass4, 1);

    // new start clears previous results; all outputs stuck high
    applyStimulus(1'b0, 2'd2, 1'b1, 3'd4, 7'h7F, 1'b0);
    checkOutput("clear_pass", pass4, 0);
    checkOutput("clear_busy", busy4, 1);
    waitDrained("stuck1");

    // reset during vector 2 with XOR fault: no done expected afterwards
    applyStimulus(1'b0, 2'd1, 1'b0, 3'd0, 7'h00, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("mid_ab",   {bus4.a, bus4.b}, 2);
    checkOutput("mid_err",  err4,  1);
    checkOutput("mid_mask", mask4, 7'b0100000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mrst_ab",   {bus4.a, bus4.b}, 0);
    checkOutput("mrst_busy", busy4, 0);
    checkOutput("mrst_err",  err4,  0);
    checkOutput("mrst_mask", mask4, 0);
    checkOutput("mrst_done", done4, 0);
    repeat (30) @(negedge clk);
    checkOutput("mrst_idle_busy", busy4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
